// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: Moore FSM sharing one memory port and one ALU across cycles,
// with a memory-wait timeout and a sticky fault state.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_instr_code,
  input  logic       i_mem_ready,
  output logic [3:0] o_state,
  output logic       o_pc_wr,
  output logic       o_beq,
  output logic       o_bne,
  output logic [1:0] o_pc_src,
  output logic       o_iord,
  output logic       o_ir_wr,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_mem_reg,
  output logic       o_reg_dst,
  output logic       o_reg_wr,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_extend,
  output logic       o_fault
);

  localparam logic [5:0] OP_RTYP  = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SOLT  = 6'b101010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_JUMP  = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_FAULT    = 4'd15
  } state_e;

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_wait;
  logic             w_timeout;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Timeout fires on the last allowed not-ready cycle; ready on that cycle still wins.
  always_comb begin
    w_wait    = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    w_timeout = w_wait && !i_mem_ready && (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LIMIT);
  end

  always_comb begin
    w_next = S_FAULT;
    case (r_state)
      S_IDLE:     w_next = S_FETCH;
      S_FETCH:    w_next = w_timeout ? S_FAULT : (i_mem_ready ? S_DECODE : S_FETCH);
      S_DECODE: begin
        case (i_instr_code)
          OP_RTYP:           w_next = S_EXEC_R;
          OP_ADDIU, OP_SOLT: w_next = S_EXEC_I;
          OP_LW, OP_SW:      w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:    w_next = S_BRANCH;
          OP_JUMP:           w_next = S_JUMP;
          default:           w_next = S_FAULT;
        endcase
      end
      S_MEM_ADDR: begin
        if (i_instr_code == OP_LW)      w_next = S_MEM_RD;
        else if (i_instr_code == OP_SW) w_next = S_MEM_WR;
        else                            w_next = S_FAULT;
      end
      S_MEM_RD:   w_next = w_timeout ? S_FAULT : (i_mem_ready ? S_MEM_WB : S_MEM_RD);
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = w_timeout ? S_FAULT : (i_mem_ready ? S_FETCH : S_MEM_WR);
      S_EXEC_R:   w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_EXEC_I:   w_next = S_I_WB;
      S_I_WB:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      default:    w_next = S_FAULT;
    endcase
  end

  // Counter only runs while staying in a wait state without ready; anything else clears it.
  always_comb begin
    w_cnt_next = '0;
    if (w_wait && !i_mem_ready && (w_next == r_state)) begin
      w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    o_pc_wr     = 1'b0;
    o_beq       = 1'b0;
    o_bne       = 1'b0;
    o_pc_src    = 2'b00;
    o_iord      = 1'b0;
    o_ir_wr     = 1'b0;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_reg   = 1'b0;
    o_reg_dst   = 1'b0;
    o_reg_wr    = 1'b0;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 2'b00;
    o_alu_op    = 2'b00;
    o_extend    = 1'b0;
    o_fault     = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_rd    = 1'b1;
        o_alu_src_b = 2'b01;
        o_ir_wr     = i_mem_ready;
        o_pc_wr     = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_b = 2'b11;
        o_extend    = 1'b1;
      end
      S_MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_extend    = 1'b1;
      end
      S_MEM_RD: begin
        o_mem_rd = 1'b1;
        o_iord   = 1'b1;
      end
      S_MEM_WB: begin
        o_reg_wr  = 1'b1;
        o_mem_reg = 1'b1;
      end
      S_MEM_WR: begin
        o_mem_wr = 1'b1;
        o_iord   = 1'b1;
      end
      S_EXEC_R: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b10;
      end
      S_R_WB: begin
        o_reg_wr  = 1'b1;
        o_reg_dst = 1'b1;
      end
      S_EXEC_I: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_alu_op    = 2'b11;
      end
      S_I_WB:   o_reg_wr = 1'b1;
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b01;
        o_pc_src    = 2'b01;
        o_beq       = (i_instr_code == OP_BEQ);
        o_bne       = (i_instr_code == OP_BNE);
      end
      S_JUMP: begin
        o_pc_wr  = 1'b1;
        o_pc_src = 2'b10;
      end
      S_FAULT:  o_fault = 1'b1;
      default:  ;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model builds the
// expected state walk and per-state control word; random opcodes and memory latencies.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 15;

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3,
                         MEM_RD = 4'd4, MEM_WB = 4'd5, MEM_WR = 4'd6, EXEC_R = 4'd7,
                         R_WB = 4'd8, EXEC_I = 4'd9, I_WB = 4'd10, BRANCH = 4'd11,
                         JUMP = 4'd12, FAULT = 4'd15;

  localparam logic [5:0] RTYP = 6'b000000, ADDIU = 6'b001001, SOLT = 6'b101010,
                         BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010,
                         LW = 6'b100011, SW = 6'b101011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       rdy;
  logic [3:0] o_state;
  logic       o_pc_wr, o_beq, o_bne, o_iord, o_ir_wr, o_mem_rd, o_mem_wr, o_mem_reg;
  logic       o_reg_dst, o_reg_wr, o_alu_src_a, o_extend, o_fault;
  logic [1:0] o_pc_src, o_alu_src_b, o_alu_op;
  logic [18:0] w_outs;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr_code(op), .i_mem_ready(rdy),
    .o_state(o_state), .o_pc_wr(o_pc_wr), .o_beq(o_beq), .o_bne(o_bne),
    .o_pc_src(o_pc_src), .o_iord(o_iord), .o_ir_wr(o_ir_wr), .o_mem_rd(o_mem_rd),
    .o_mem_wr(o_mem_wr), .o_mem_reg(o_mem_reg), .o_reg_dst(o_reg_dst),
    .o_reg_wr(o_reg_wr), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
    .o_alu_op(o_alu_op), .o_extend(o_extend), .o_fault(o_fault)
  );

  assign w_outs = {o_pc_wr, o_beq, o_bne, o_pc_src, o_iord, o_ir_wr, o_mem_rd, o_mem_wr,
                   o_mem_reg, o_reg_dst, o_reg_wr, o_alu_src_a, o_alu_src_b, o_alu_op,
                   o_extend, o_fault};

  // Control word the specification lists for each state.
  function automatic logic [18:0] exp_out(input logic [3:0] s, input logic [5:0] opc,
                                          input logic r);
    logic pc_wr, beq, bne, iord, ir_wr, mrd, mwr, mreg, rdst, rwr, asa, ext, flt;
    logic [1:0] psrc, asb, aop;
    {pc_wr, beq, bne, iord, ir_wr, mrd, mwr, mreg, rdst, rwr, asa, ext, flt} = '0;
    {psrc, asb, aop} = '0;
    case (s)
      FETCH:    begin mrd = 1; asb = 2'b01; ir_wr = r; pc_wr = r; end
      DECODE:   begin asb = 2'b11; ext = 1; end
      MEM_ADDR: begin asa = 1; asb = 2'b10; ext = 1; end
      MEM_RD:   begin mrd = 1; iord = 1; end
      MEM_WB:   begin rwr = 1; mreg = 1; end
      MEM_WR:   begin mwr = 1; iord = 1; end
      EXEC_R:   begin asa = 1; aop = 2'b10; end
      R_WB:     begin rwr = 1; rdst = 1; end
      EXEC_I:   begin asa = 1; asb = 2'b10; aop = 2'b11; end
      I_WB:     rwr = 1;
      BRANCH:   begin asa = 1; aop = 2'b01; psrc = 2'b01; beq = (opc == BEQ); bne = (opc == BNE); end
      JUMP:     begin pc_wr = 1; psrc = 2'b10; end
      FAULT:    flt = 1;
      default:  ;
    endcase
    return {pc_wr, beq, bne, psrc, iord, ir_wr, mrd, mwr, mreg, rdst, rwr, asa, asb, aop, ext, flt};
  endfunction

  // One clock: drive inputs at the falling edge, check state and outputs, let the edge pass.
  task automatic step_r(input logic [3:0] es, input logic r, input logic rst_v);
    @(negedge clk);
    rdy   = r;
    rst_n = rst_v;
    #1;
    n_chk++;
    assert (o_state === es) else begin
      n_fail++;
      $error("FAIL state: observed %0d expected %0d", o_state, es);
    end
    n_chk++;
    assert (w_outs === exp_out(es, op, r)) else begin
      n_fail++;
      $error("FAIL outputs in state %0d: observed %b expected %b", es, w_outs, exp_out(es, op, r));
    end
  endtask

  task automatic step(input logic [3:0] es, input logic r);
    step_r(es, r, 1'b1);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // w not-ready cycles then ready; w >= TO means the timeout expires first.
  task automatic wait_phase(input logic [3:0] st, input int w, output logic faulted);
    int k;
    k = (w < int'(TO)) ? w : int'(TO);
    faulted = 1'b0;
    for (int i = 0; i < k; i++) step(st, 1'b0);
    if (w >= int'(TO)) faulted = 1'b1;
    else step(st, 1'b1);
  endtask

  task automatic run_instr(input logic [5:0] opc, input int wf, input int wm,
                           output logic faulted);
    op = opc;
    wait_phase(FETCH, wf, faulted);
    if (faulted) return;
    step(DECODE, rnd_bit());
    case (opc)
      RTYP:        begin step(EXEC_R, rnd_bit()); step(R_WB, rnd_bit()); end
      ADDIU, SOLT: begin step(EXEC_I, rnd_bit()); step(I_WB, rnd_bit()); end
      LW: begin
        step(MEM_ADDR, rnd_bit());
        wait_phase(MEM_RD, wm, faulted);
        if (!faulted) step(MEM_WB, rnd_bit());
      end
      SW: begin
        step(MEM_ADDR, rnd_bit());
        wait_phase(MEM_WR, wm, faulted);
      end
      BEQ, BNE:    step(BRANCH, rnd_bit());
      JMP:         step(JUMP, rnd_bit());
      default:     faulted = 1'b1;
    endcase
  endtask

  // Reset asserted while in state cur; IDLE and a cleared counter must follow.
  task automatic pulse_reset(input logic [3:0] cur, input logic r);
    step_r(cur, r, 1'b0);
    step_r(IDLE, rnd_bit(), 1'b1);
    n_chk++;
    assert (dut.r_cnt === 8'd0) else begin
      n_fail++;
      $error("FAIL wait counter after reset: observed %0d expected 0", dut.r_cnt);
    end
  endtask

  task automatic fault_and_reset(input int n);
    for (int i = 0; i < n; i++) step(FAULT, rnd_bit());
    pulse_reset(FAULT, rnd_bit());
  endtask

  initial begin
    logic       f;
    logic [5:0] legal [8];
    logic [5:0] illegal [4];
    int         sel;
    int         wf;
    int         wm;
    legal   = '{RTYP, ADDIU, SOLT, BEQ, BNE, JMP, LW, SW};
    illegal = '{6'b111111, 6'b000001, 6'b110000, 6'b001000};
    rst_n = 1'b0;
    op    = 6'd0;
    rdy   = 1'b0;
    repeat (2) @(posedge clk);
    step_r(IDLE, 1'b1, 1'b0);
    step_r(IDLE, 1'b0, 1'b1);

    // Directed scenarios.
    run_instr(ADDIU, 0, 0, f);
    run_instr(LW, 3, 3, f);
    run_instr(BNE, 0, 0, f);
    run_instr(BEQ, 1, 0, f);
    run_instr(JMP, 0, 0, f);
    run_instr(RTYP, 2, 0, f);
    run_instr(SW, 0, 14, f);
    run_instr(SOLT, 14, 0, f);
    run_instr(6'b111111, 0, 0, f);
    step(FAULT, 1'b1);
    fault_and_reset(20);
    run_instr(SW, 0, 15, f);
    fault_and_reset(3);
    run_instr(LW, 15, 0, f);
    fault_and_reset(2);

    // Reset mid-read, then a near-limit wait must not fault.
    op = LW;
    step(FETCH, 1'b1);
    step(DECODE, 1'b0);
    step(MEM_ADDR, 1'b1);
    for (int i = 0; i < 5; i++) step(MEM_RD, 1'b0);
    pulse_reset(MEM_RD, 1'b0);
    run_instr(LW, 14, 14, f);

    // Randomised instruction stream.
    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom_range(0, 11));
      wf  = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
      wm  = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
      if (sel == 10) wm = int'(TO) + int'($urandom_range(0, 2));
      if (sel == 11) wf = int'(TO);
      if (sel == 9) begin
        run_instr(illegal[$urandom_range(0, 3)], wf, wm, f);
        if (f) step(FAULT, rnd_bit());
      end else begin
        run_instr(legal[(sel >= 8) ? (6 + (sel & 1)) : sel], wf, wm, f);
      end
      if (f) fault_and_reset(int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
